// File: rtl/serial_frame_receiver_6bit.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver_6bit
//
// Receives LSB-first framed 6-bit words from a single serial line, qualified by
// a one-cycle bit strobe, and presents each good word behind a valid/ready
// handshake with a one-entry output buffer.
//
// Frame on the line, one bit per bit_en strobe:
//   start (1), d0..d5, [even parity p], stop (0)
//
// Ports:
//   clk          system clock, all state changes on posedge
//   clear        synchronous active-high reset, priority over all inputs
//   bit_en       line-bit strobe; serial_in consumed only when high
//   serial_in    serial line, idles at 0
//   data_ready   downstream accepts data_out this cycle
//   data_out     received word, bit 0 = first data bit on the line
//   data_valid   data_out holds an unconsumed word
//   parity_err   one-cycle pulse: frame discarded for bad parity
//   frame_err    one-cycle pulse: frame discarded for bad stop bit
//   overrun      sticky: a good frame was dropped because the buffer was full
//   frame_count  good frames accepted into the buffer, modulo 16
//   busy         receiver is inside a frame (state is not IDLE)
// -----------------------------------------------------------------------------
module serial_frame_receiver_6bit #(
    parameter int PARITY_EN = 1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       serial_in,
    input  logic       data_ready,
    output logic [5:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [3:0] frame_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] rx_q, rx_d;
    logic       par_q, par_d;
    logic [5:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       par_ok;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 6'd0;
            par_q     <= 1'b0;
            data_q    <= 6'd0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
        cnt_d     = cnt_q;
        // Without a parity bit every frame with a good stop bit is accepted.
        par_ok    = (PARITY_EN == 0) || (par_q == ^rx_q);

        // Transfer drains the buffer; a load in STOP below may refill it on
        // the same edge.
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (serial_in) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    rx_d[bit_cnt_q] = serial_in;
                    bit_cnt_d       = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd5) begin
                        bit_cnt_d = 3'd0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = serial_in;
                    state_d = STOP;
                end
                STOP: begin
                    // Always back to IDLE: the stop bit can never restart a frame.
                    state_d = IDLE;
                    if (serial_in) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || data_ready) begin
                        data_d  = rx_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;
    assign frame_count = cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver_6bit.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for serial_frame_receiver_6bit (PARITY_EN=1).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver_6bit;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       bit_en = 1'b0;
    logic       serial_in = 1'b0;
    logic       data_ready = 1'b1;
    logic [5:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [3:0] frame_count;
    logic       busy;

    int total = 0;
    int fails = 0;

    serial_frame_receiver_6bit #(.PARITY_EN(1)) dut (
        .clk         (clk),
        .clear       (clear),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .data_ready  (data_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One line bit, preceded by 'gap' non-strobe cycles carrying random junk.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bit_en    = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bit_en    = 1'b1;
        serial_in = b;
    endtask

    // Full frame; with tail=1 it returns on the negedge right after the edge
    // that sampled the stop bit, where results are visible.
    task automatic send_frame(input logic [5:0] d, input logic p, input logic stop,
                              input int gap, input bit tail);
        send_bit(1'b1, gap);
        for (int i = 0; i < 6; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(stop, gap);
        if (tail) begin
            @(negedge clk);
            bit_en    = 1'b0;
            serial_in = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bit_en = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
    endtask

    initial begin
        logic [5:0] d;

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        clear = 1'b0;
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // clear mid-frame
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        bit_en = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_out", 32'(data_out), 32'd0);
        chk("clr_flags", 32'({data_valid, parity_err, frame_err, overrun}), 32'd0);
        chk("clr_count", 32'(frame_count), 32'd0);

        // ---------------- good frame, bit_en every cycle ----------------
        data_ready = 1'b1;
        send_frame(6'b101101, 1'b0, 1'b0, 0, 1'b1);
        chk("good_out", 32'(data_out), 32'h2d);
        chk("good_valid", 32'(data_valid), 32'd1);
        chk("good_count", 32'(frame_count), 32'd1);
        chk("good_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("good_drain", 32'(data_valid), 32'd0);

        // ---------------- gapped strobes ----------------
        send_frame(6'b101101, 1'b0, 1'b0, 2, 1'b1);
        chk("gap_out", 32'(data_out), 32'h2d);
        chk("gap_valid", 32'(data_valid), 32'd1);
        chk("gap_count", 32'(frame_count), 32'd2);
        chk("gap_errs", 32'({parity_err, frame_err}), 32'd0);
        @(negedge clk);
        chk("gap_drain", 32'(data_valid), 32'd0);

        // ---------------- parity and framing errors ----------------
        pulse_clear();
        send_frame(6'b101101, 1'b1, 1'b0, 0, 1'b1);
        chk("perr_pulse", 32'(parity_err), 32'd1);
        chk("perr_ferr", 32'(frame_err), 32'd0);
        chk("perr_valid", 32'(data_valid), 32'd0);
        chk("perr_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        chk("perr_one_cycle", 32'(parity_err), 32'd0);
        send_frame(6'b101101, 1'b0, 1'b1, 0, 1'b1);
        chk("ferr_pulse", 32'(frame_err), 32'd1);
        chk("ferr_perr", 32'(parity_err), 32'd0);
        chk("ferr_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        chk("ferr_one_cycle", 32'(frame_err), 32'd0);
        chk("ferr_count", 32'(frame_count), 32'd0);
        // frame error wins over parity error
        send_frame(6'b101101, 1'b1, 1'b1, 0, 1'b1);
        chk("both_errs", 32'({parity_err, frame_err}), 32'b01);

        // ---------------- backpressure and overrun ----------------
        data_ready = 1'b0;
        send_frame(6'b101101, 1'b0, 1'b0, 0, 1'b1);
        chk("bp_valid", 32'(data_valid), 32'd1);
        chk("bp_ovr0", 32'(overrun), 32'd0);
        send_frame(6'b010101, 1'b1, 1'b0, 0, 1'b1);
        chk("ovr_out", 32'(data_out), 32'h2d);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_count", 32'(frame_count), 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        chk("ovr_drain", 32'(data_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // ---------------- reset mid-frame, then wrap ----------------
        data_ready = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        pulse_clear();
        chk("rmf_ovr", 32'(overrun), 32'd0);
        send_frame(6'b111111, 1'b0, 1'b0, 0, 1'b1);
        chk("rmf_out", 32'(data_out), 32'h3f);
        chk("rmf_count", 32'(frame_count), 32'd1);
        // 16 back-to-back frames: start strobe immediately follows each stop
        for (int i = 0; i < 16; i++) begin
            d = 6'((i * 5) & 63);
            send_frame(d, ^d, 1'b0, 0, (i == 15));
        end
        chk("wrap_out", 32'(data_out), 32'h0b);
        chk("wrap_valid", 32'(data_valid), 32'd1);
        chk("wrap_count", 32'(frame_count), 32'd1);
        chk("wrap_errs", 32'({parity_err, frame_err, overrun}), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver_6bit.md
# serial_frame_receiver_6bit

Receives framed 6-bit words from a single serial line and presents them as parallel words behind a valid/ready handshake. It sits directly downstream of the 6-bit parallel-to-serial converter: it consumes that converter's LSB-first bit stream, qualified by a one-cycle bit strobe. The block hunts for a start bit, assembles six data bits, checks even parity and the stop bit, then holds each good word in a one-entry output buffer. Framing errors, parity errors and overruns are flagged.

## Interface
- PARITY_EN, default 1: 1 = frame carries a parity bit between data and stop; 0 = no parity bit, PARITY state skipped, parity_err never asserts.
- clk  input  1  system clock; all state changes on posedge.
- clear  input  1  synchronous, active-high reset; one clock; polarity and synchronicity fixed.
- bit_en  input  1  line-bit strobe; serial_in is consumed only on cycles with bit_en=1.
- serial_in  input  1  serial line; idle level 0.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  6  received word, bit 0 = first data bit on the line.
- data_valid  output  1  data_out holds an unconsumed word.
- parity_err  output  1  one-cycle pulse: frame discarded for bad parity.
- frame_err  output  1  one-cycle pulse: frame discarded for bad stop bit.
- overrun  output  1  sticky; a good frame was dropped because the buffer was full. Cleared only by clear.
- frame_count  output  4  number of good frames accepted into the buffer, modulo 16.
- busy  output  1  state is not IDLE.

## Operation
- Frame on the line, one bit per bit_en: start (1), d0..d5 (LSB first), parity p (even: p = d0^…^d5), stop (0).
- States: IDLE, DATA, PARITY, STOP. Cycles with bit_en=0 never change state, the bit counter, or the shift register.
- IDLE: when bit_en=1 and serial_in=1, go to DATA with bit_cnt=0. A 0 on the line is ignored as idle.
- DATA: on each bit_en, rx[bit_cnt] <= serial_in and bit_cnt increments. After d5 is taken (bit_cnt 5), go to PARITY, or to STOP when PARITY_EN=0.
- PARITY: on bit_en, latch p and go to STOP.
- STOP: on bit_en, always return to IDLE. The stop-bit cycle is never treated as a new start bit. Outcome:
  - serial_in=1: frame_err pulse; word discarded.
  - Stop bit OK but p != ^rx: parity_err pulse; word discarded.
  - Stop bit OK, parity OK, buffer free or draining this cycle (data_valid=0, or data_ready=1): data_out <= rx, data_valid <= 1, frame_count increments (15 wraps to 0).
  - Stop bit OK, parity OK, buffer full and data_ready=0: word dropped; overrun <= 1; data_out unchanged; frame_count unchanged.
  - Frame error takes priority over parity error; at most one error pulse per frame.
- Handshake: a transfer occurs on any edge where data_valid=1 and data_ready=1.
  - After a transfer, data_valid falls unless a new word loads on the same edge, in which case it stays 1 with the new data_out.
  - data_out must not change while data_valid=1 except at a transfer edge.
- Reset: clear=1 at an edge forces IDLE, bit_cnt=0, rx=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, frame_count=0, busy=0. This holds regardless of state; a partial frame is discarded. clear has priority over every other input.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: data_valid, parity_err or frame_err is visible one cycle after the edge that samples the stop bit (i.e. after that edge).
- Error pulses last exactly one cycle.
- busy rises after the edge sampling the start bit and falls after the edge sampling the stop bit.
- Minimum frame length: 9 bit_en strobes (8 when PARITY_EN=0). Back-to-back frames with bit_en held high are supported; the next start bit may be on the strobe right after the stop bit.
- data_ready may toggle on any cycle; no dependency on bit_en.

## Test plan
- Reset: drive clear for 1 cycle mid-activity → all outputs 0 on the next cycle; busy=0.
- Good frame, PARITY_EN=1, data_ready=1, bit_en every cycle; line 1,1,0,1,1,0,1,0,0 → data_out=6'b101101, data_valid=1 for exactly 1 cycle, frame_count=1, no error flags.
- Gapped strobes: same frame with bit_en high only every 3rd cycle, random serial_in on non-strobe cycles → identical result to the previous scenario.
- Errors: 6'b101101 sent with p=1 → parity_err pulse, data_valid stays 0, frame_count=0. Then the same frame with p=0 and stop=1 → frame_err pulse only.
- Backpressure and overrun: data_ready=0; send 6'b101101 then 6'b010101 (p=1) → data_out stays 101101, data_valid=1, overrun=1, frame_count=1. Then data_ready=1 for 1 cycle → data_valid=0 on the following cycle; overrun remains 1.
- Reset mid-frame: clear after start and 3 data bits, then send 6'b111111 (p=0) → only 6'b111111 delivered, frame_count=1. After 16 further good frames, frame_count wraps to 1.
